// File: rtl/bus_responder_dmtc_if.sv
// Data-memory bus between the core's M stage (master) and the memory/timer responder (slave).
interface bus_responder_dmtc_if;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        irq;
    logic        bus_err;
    logic [31:0] bus_err_pc;

    modport master (
        output m_data_addr,
        output m_data_wdata,
        output m_data_byteen,
        output m_inst_addr,
        input  m_data_rdata,
        input  irq,
        input  bus_err,
        input  bus_err_pc
    );

    modport slave (
        input  m_data_addr,
        input  m_data_wdata,
        input  m_data_byteen,
        input  m_inst_addr,
        output m_data_rdata,
        output irq,
        output bus_err,
        output bus_err_pc
    );
endinterface

// File: rtl/bus_responder_dmtc.sv
// Data-memory bus responder: byte-enable data memory plus one memory-mapped down-counter timer
// with interrupt request and illegal-access reporting.
module bus_responder_dmtc #(
    parameter int unsigned DM_WORDS   = 3072,
    parameter logic [31:0] TIMER_BASE = 32'h7F00
) (
    input logic                 clk,
    input logic                 reset,
    bus_responder_dmtc_if.slave bus
);
    localparam int unsigned DmAw       = $clog2(DM_WORDS);
    localparam logic [29:0] CtrlWord   = TIMER_BASE[31:2];
    localparam logic [29:0] PresetWord = CtrlWord + 30'd1;
    localparam logic [29:0] CountWord  = CtrlWord + 30'd2;

    typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;        // {IM, MODE[1:0], EN}
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;
    logic        irq_q, irq_d;
    logic        bus_err_q;
    logic [31:0] bus_err_pc_q;

    logic [31:0] mem [DM_WORDS];

    logic [29:0]     word;
    logic [DmAw-1:0] dm_idx;
    logic            is_dm, is_ctrl, is_preset, is_count;
    logic            is_write, full_word, legal, err;
    logic            dm_we, ctrl_we, preset_we;
    logic [31:0]     rdata;
    logic            unused_addr_lsbs;

    assign word             = bus.m_data_addr[31:2];
    assign unused_addr_lsbs = ^bus.m_data_addr[1:0];
    assign dm_idx           = word[DmAw-1:0];
    assign is_dm            = {2'b00, word} < DM_WORDS;
    assign is_ctrl          = word == CtrlWord;
    assign is_preset        = word == PresetWord;
    assign is_count         = word == CountWord;

    assign is_write  = bus.m_data_byteen != 4'h0;
    assign full_word = bus.m_data_byteen == 4'hF;
    // COUNT is read-only and timer registers take whole words only; anything else unmapped errors.
    assign legal     = is_dm || ((is_ctrl || is_preset) && full_word);
    assign err       = is_write && !legal;
    assign dm_we     = is_write && is_dm;
    assign ctrl_we   = is_ctrl && full_word;
    assign preset_we = is_preset && full_word;

    always_comb begin
        rdata = 32'h0;
        if (is_dm) begin
            rdata = mem[dm_idx];
        end else if (is_ctrl) begin
            rdata = {28'h0, ctrl_q};
        end else if (is_preset) begin
            rdata = preset_q;
        end else if (is_count) begin
            rdata = count_q;
        end
    end

    assign bus.m_data_rdata = rdata;
    assign bus.irq          = irq_q;
    assign bus.bus_err      = bus_err_q;
    assign bus.bus_err_pc   = bus_err_pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DM_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (dm_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.m_data_byteen[b]) begin
                    mem[dm_idx][b*8 +: 8] <= bus.m_data_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            StIdle: begin
                if (ctrl_q[0]) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!ctrl_q[0]) begin
                    state_d = StIdle;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = 32'h0;
                    irq_flag_d = 1'b1;
                    state_d    = StInt;
                end
            end
            StInt: begin
                if (ctrl_q[2:1] == 2'b01) begin
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A CPU write to CTRL overrides whatever the FSM did to EN this cycle.
        if (ctrl_we) begin
            ctrl_d = bus.m_data_wdata[3:0];
            if (bus.m_data_wdata[0]) begin
                irq_flag_d = 1'b0;
            end
        end
        if (preset_we) begin
            preset_d = bus.m_data_wdata;
        end

        irq_d = irq_flag_d & ctrl_d[3];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            ctrl_q       <= 4'h0;
            preset_q     <= 32'h0;
            count_q      <= 32'h0;
            irq_flag_q   <= 1'b0;
            irq_q        <= 1'b0;
            bus_err_q    <= 1'b0;
            bus_err_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
            bus_err_q  <= err;
            if (err) begin
                bus_err_pc_q <= bus.m_inst_addr;
            end
        end
    end
endmodule

// File: tb/tb_bus_responder_dmtc.sv
// Directed self-checking bench for bus_responder_dmtc: memory lanes, timer modes, bus errors, reset.
module tb_bus_responder_dmtc;
    localparam logic [31:0] TBase  = 32'h7F00;
    localparam logic [31:0] TCtrl  = TBase;
    localparam logic [31:0] TPre   = TBase + 32'd4;
    localparam logic [31:0] TCount = TBase + 32'd8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [31:0] rd;

    // Indexed by the number of clock edges since the CTRL write landed.
    int unsigned os_count [8] = '{0, 0, 5, 4, 3, 2, 1, 0};
    int unsigned os_irq   [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    bus_responder_dmtc_if bus ();

    bus_responder_dmtc #(
        .DM_WORDS  (3072),
        .TIMER_BASE(TBase)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be, input logic [31:0] pc);
        @(negedge clk);
        bus.m_data_addr   = addr;
        bus.m_data_wdata  = data;
        bus.m_data_byteen = be;
        bus.m_inst_addr   = pc;
        @(posedge clk);
        #1;
        bus.m_data_byteen = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.m_data_addr   = addr;
        bus.m_data_byteen = 4'h0;
        #1;
        data = bus.m_data_rdata;
    endtask

    initial begin
        n_checks          = 0;
        n_pass            = 0;
        reset             = 1'b0;
        bus.m_data_addr   = 32'h0;
        bus.m_data_wdata  = 32'h0;
        bus.m_data_byteen = 4'h0;
        bus.m_inst_addr   = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        bus_read(32'h0, rd);
        check_eq("rst_dm0", rd, 32'h0);
        bus_read(32'h2FFC, rd);
        check_eq("rst_dm_last", rd, 32'h0);
        bus_read(TCount, rd);
        check_eq("rst_count", rd, 32'h0);
        check_eq("rst_irq", 32'(bus.irq), 32'h0);
        check_eq("rst_bus_err", 32'(bus.bus_err), 32'h0);

        // Byte-lane merge and read-old-during-write.
        bus_write(32'h1000, 32'hAABBCCDD, 4'hF, 32'h100);
        @(negedge clk);
        bus.m_data_addr   = 32'h1000;
        bus.m_data_wdata  = 32'h11223344;
        bus.m_data_byteen = 4'b0101;
        #1;
        check_eq("dm_same_cycle_old", bus.m_data_rdata, 32'hAABBCCDD);
        @(posedge clk);
        #1;
        bus.m_data_byteen = 4'h0;
        bus_read(32'h1000, rd);
        check_eq("dm_lane_merge", rd, 32'hAA22CC44);
        bus_read(32'h1002, rd);
        check_eq("dm_addr_lsb_ignored", rd, 32'hAA22CC44);
        bus_read(32'h1004, rd);
        check_eq("dm_neighbour", rd, 32'h0);
        bus_write(32'h2FFC, 32'hCAFEF00D, 4'hF, 32'h104);
        check_eq("dm_last_no_err", 32'(bus.bus_err), 32'h0);
        bus_read(32'h2FFC, rd);
        check_eq("dm_last_word", rd, 32'hCAFEF00D);

        // One-shot timer: PRESET=5, CTRL = IM | EN.
        bus_write(TPre, 32'd5, 4'hF, 32'h200);
        bus_write(TCtrl, 32'h9, 4'hF, 32'h204);
        for (int k = 0; k < 8; k++) begin
            bus_read(TCount, rd);
            check_eq($sformatf("os_count_%0d", k), rd, 32'(os_count[k]));
            check_eq($sformatf("os_irq_%0d", k), 32'(bus.irq), 32'(os_irq[k]));
        end
        repeat (3) @(negedge clk);
        bus_read(TCtrl, rd);
        check_eq("os_ctrl_en_cleared", rd, 32'h8);
        check_eq("os_irq_held", 32'(bus.irq), 32'h1);
        bus_read(TCount, rd);
        check_eq("os_count_stays0", rd, 32'h0);
        bus_write(TCtrl, 32'h0, 4'hF, 32'h208);
        check_eq("os_irq_masked", 32'(bus.irq), 32'h0);

        // Auto-reload, PRESET=3: LOAD, three CNT cycles (the last expires), INT, IDLE -> 6 cycles.
        bus_write(TPre, 32'd3, 4'hF, 32'h300);
        bus_write(TCtrl, 32'hB, 4'hF, 32'h304);
        for (int k = 0; k < 14; k++) begin
            bus_read(TCount, rd);
            check_eq($sformatf("ar_irq_%0d", k), 32'(bus.irq), ((k == 5) || (k == 11)) ? 32'h1 : 32'h0);
            if (k == 8) begin
                check_eq("ar_reload", rd, 32'd3);
            end
        end
        // Disable lands while CNT has just decremented 3 -> 2; COUNT then freezes.
        bus_write(TCtrl, 32'h0, 4'hF, 32'h308);
        repeat (3) @(negedge clk);
        bus_read(TCount, rd);
        check_eq("ar_count_frozen", rd, 32'd2);

        // Illegal accesses.
        bus_write(32'h3000, 32'hDEADBEEF, 4'hF, 32'h400100);
        check_eq("err_unmapped", 32'(bus.bus_err), 32'h1);
        check_eq("err_unmapped_pc", bus.bus_err_pc, 32'h400100);
        @(posedge clk);
        #1;
        check_eq("err_one_cycle", 32'(bus.bus_err), 32'h0);
        bus_write(TCtrl, 32'hF, 4'b0011, 32'h400200);
        check_eq("err_partial_ctrl", 32'(bus.bus_err), 32'h1);
        check_eq("err_partial_ctrl_pc", bus.bus_err_pc, 32'h400200);
        bus_read(TCtrl, rd);
        check_eq("err_ctrl_unchanged", rd, 32'h0);
        bus_write(TCount, 32'h12345678, 4'hF, 32'h400300);
        check_eq("err_count_write", 32'(bus.bus_err), 32'h1);
        check_eq("err_count_pc", bus.bus_err_pc, 32'h400300);
        bus_read(TCount, rd);
        check_eq("err_count_unchanged", rd, 32'd2);
        bus_read(32'h3000, rd);
        check_eq("unmapped_read0", rd, 32'h0);
        @(posedge clk);
        #1;
        check_eq("read_no_err", 32'(bus.bus_err), 32'h0);
        check_eq("err_pc_held", bus.bus_err_pc, 32'h400300);

        // Asynchronous reset in the middle of counting.
        bus_write(TPre, 32'd10, 4'hF, 32'h500);
        bus_write(TCtrl, 32'h1, 4'hF, 32'h504);
        repeat (5) @(negedge clk);
        bus_read(TCount, rd);
        check_eq("mid_cnt_7", rd, 32'd7);
        #1;
        reset = 1'b0;
        #1;
        check_eq("async_count", bus.m_data_rdata, 32'h0);
        check_eq("async_irq", 32'(bus.irq), 32'h0);
        check_eq("async_err_pc", bus.bus_err_pc, 32'h0);
        bus.m_data_addr = 32'h1000;
        #1;
        check_eq("async_dm", bus.m_data_rdata, 32'h0);
        bus.m_data_addr = TCtrl;
        #1;
        check_eq("async_ctrl", bus.m_data_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(TCount, rd);
        check_eq("post_reset_idle", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
